ifm_fetch_ctrl: RTL and testbench
=================================

Name: ifm_fetch_ctrl

Overview:
- Read-side controller that sits directly downstream of the IFM BRAM.
- Walks a rectangular tile of IFM words (rows x cols, with a row stride) and drives the BRAM read address as a byte address. The BRAM uses the byte address divided by 4 as its word index.
- Captures the BRAM's registered read data and delivers it to the PE array as a valid/ready stream.
- Absorbs downstream back-pressure through a credit-controlled skid FIFO, so no read data is ever lost.

Parameters:
- DATA_W, 32, BRAM word width / stream width.
- RADDR_W, 20, BRAM read byte-address width.
- WADDR_W, 18, word-address width (RADDR_W-2).
- DIM_W, 10, width of row/col/stride fields.
- FIFO_DEPTH, 4, skid FIFO entries; must be >= 3 for full throughput.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous active-high reset.
- start  in  1  one-cycle pulse; launches a tile fetch when idle.
- cfg_base  in  WADDR_W  word address of tile element (0,0).
- cfg_rows  in  DIM_W  tile rows.
- cfg_cols  in  DIM_W  words per row.
- cfg_stride  in  DIM_W  word distance between row starts.
- rd_addr  out  RADDR_W  BRAM read byte address, registered.
- bram_data  in  DATA_W  BRAM data_out (valid 1 edge after rd_addr).
- out_data  out  DATA_W  stream data (FIFO head).
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready from consumer.
- out_last  out  1  marks the final word of the tile.
- busy  out  1  high from the start-accept edge until the done edge.
- done  out  1  one-cycle pulse when the last beat is accepted.

Behaviour:

Reset (asynchronous, reset=1):
- rd_addr=0, out_valid=0, out_last=0, out_data=0, busy=0, done=0.
- FIFO emptied, in-flight pipe cleared, FSM=IDLE, all counters 0.
- Reset mid-tile aborts the fetch: no done pulse, and no stale beat after release.

Configuration and FSM:
- cfg_* are sampled only on the start-accept edge.
- IDLE:
  - start=1 with rows!=0 and cols!=0: go to FETCH, busy=1, and issue the first read on the same edge.
  - start=1 with rows==0 or cols==0: done=1 on the next edge, busy stays 0, no reads, FSM stays IDLE.
- FETCH: issues reads in raster order (col fastest); go to DRAIN after the read for (rows-1, cols-1) is issued.
- DRAIN: no new issues; wait for the final beat to be accepted, then go to IDLE with done=1 for 1 cycle and busy=0 on that edge.
- start while busy is ignored.

Addressing:
- Word address = row_base + col.
- row_base starts at cfg_base and increments by cfg_stride at each row end.
- All word arithmetic is modulo 2^WADDR_W (wraps silently).
- rd_addr = {word_addr, 2'b00}.
- rd_addr holds its last value when no read issues.

Read pipeline:
- Issue at edge E.
- BRAM registers the data at E+1.
- The word is written into the FIFO at E+2 (2-stage in-flight shift register of valid/last flags).

Credit rule:
- Issue permitted when fifo_count + inflight - pop < FIFO_DEPTH, where pop = out_valid & out_ready.
- The FIFO therefore never overflows, and no write is ever dropped.

Stream:
- out_valid = FIFO non-empty.
- out_data and out_last come from the FIFO head.
- out_data/out_last are stable while out_valid=1 and out_ready=0.
- Simultaneous push and pop is allowed, including at full and empty.

Ordering and throughput:
- Beats leave in exactly issue order.
- Exactly rows*cols beats are produced.
- out_last is set only on the final beat.
- Latency: start-accept edge to first out_valid = 2 edges.
- With out_ready held at 1 and FIFO_DEPTH>=3: one beat per cycle, no bubbles.

Test Plan:
- Basic tile: base=0x10, rows=2, cols=3, stride=8, out_ready=1 -> rd_addr sequence 0x40,0x44,0x48,0x60,0x64,0x68 on consecutive cycles; 6 beats equal to the BRAM contents at word addresses 0x10,0x11,0x12,0x18,0x19,0x1A; out_last only on beat 6; done pulse 1 cycle after beat 6; busy deasserts on the same edge.
- Back-pressure: rows=1, cols=8, out_ready toggled 1,0,0,1,0,... -> no beats lost or duplicated; issues stall once count+inflight reaches 4; out_data stable while stalled.
- Zero-size: start with cols=0 -> done=1 exactly one cycle later; busy never asserted; rd_addr unchanged; out_valid stays 0.
- Address wrap: base=0x3FFFE, rows=1, cols=4, stride=4 -> word addresses 0x3FFFE,0x3FFFF,0x00000,0x00001 (rd_addr 0xFFFF8,0xFFFFC,0x00000,0x00004).
- Reset mid-tile: assert reset asynchronously after 3 beats of a 4x4 tile -> all outputs 0 immediately; after release, a new start with rows=1, cols=2 yields exactly 2 beats with no stale data.
- Start while busy: pulse start again during FETCH with different cfg -> ignored; original tile completes with exactly rows*cols beats and a single done pulse.

Source files
------------

// File: rtl/ifm_fetch_ctrl.sv
// IFM read-side fetch controller: walks a rows x cols tile with a row stride and
// drives BRAM byte addresses. It streams the registered read data to the PE array
// through a credit-controlled skid FIFO.
module ifm_fetch_ctrl #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned RADDR_W    = 20,
  parameter int unsigned WADDR_W    = 18,
  parameter int unsigned DIM_W      = 10,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic [WADDR_W-1:0] cfg_base_i,
  input  logic [DIM_W-1:0]   cfg_rows_i,
  input  logic [DIM_W-1:0]   cfg_cols_i,
  input  logic [DIM_W-1:0]   cfg_stride_i,
  output logic [RADDR_W-1:0] rd_addr_o,
  input  logic [DATA_W-1:0]  bram_data_i,
  output logic [DATA_W-1:0]  out_data_o,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic               out_last_o,
  output logic               busy_o,
  output logic               done_o
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OccW = CntW + 1;

  typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

  state_e               state_q;
  logic [DIM_W-1:0]     rows_q, cols_q, stride_q;
  logic [DIM_W-1:0]     row_q, col_q;
  logic [WADDR_W-1:0]   base_q;
  logic [RADDR_W-1:0]   rd_addr_q;
  logic                 busy_q, done_q;

  // In-flight read pipe: stage 1 = BRAM registering, stage 2 = data on bram_data_i.
  logic                 s1_v_q, s1_l_q, s2_v_q, s2_l_q;

  logic [DATA_W-1:0]    data_q [FIFO_DEPTH];
  logic                 last_q [FIFO_DEPTH];
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]      count_q;

  // Element about to be issued and the walk position after it.
  logic [DIM_W-1:0]     i_row, i_col, i_rows, i_cols, i_stride;
  logic [WADDR_W-1:0]   i_base, i_word;
  logic                 col_end, i_last;
  logic [DIM_W-1:0]     row_d, col_d;
  logic [WADDR_W-1:0]   base_d;

  logic                 start_ok, start_zero, credit_ok, issue, push, pop;
  logic [OccW-1:0]      occ;

  assign out_valid_o = (count_q != '0);
  assign out_data_o  = data_q[rd_ptr_q];
  assign out_last_o  = last_q[rd_ptr_q];
  assign rd_addr_o   = rd_addr_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

  assign pop  = out_valid_o & out_ready_i;
  assign push = s2_v_q;

  assign start_ok   = (state_q == StIdle) && start_i && (cfg_rows_i != '0) && (cfg_cols_i != '0);
  assign start_zero = (state_q == StIdle) && start_i && ((cfg_rows_i == '0) || (cfg_cols_i == '0));

  // Everything already issued but not yet popped must fit in the FIFO.
  assign occ       = OccW'(count_q) + OccW'(s1_v_q) + OccW'(s2_v_q);
  assign credit_ok = occ < (OccW'(FIFO_DEPTH) + OccW'(pop));
  assign issue     = start_ok || ((state_q == StFetch) && credit_ok);

  // Select the element to issue (tile origin while idle) and advance the raster walk.
  always_comb begin
    if (state_q == StIdle) begin
      i_row    = '0;
      i_col    = '0;
      i_base   = cfg_base_i;
      i_rows   = cfg_rows_i;
      i_cols   = cfg_cols_i;
      i_stride = cfg_stride_i;
    end else begin
      i_row    = row_q;
      i_col    = col_q;
      i_base   = base_q;
      i_rows   = rows_q;
      i_cols   = cols_q;
      i_stride = stride_q;
    end
    col_end = (i_col == i_cols - DIM_W'(1));
    i_last  = col_end && (i_row == i_rows - DIM_W'(1));
    i_word  = i_base + WADDR_W'(i_col);
    col_d   = col_end ? '0 : i_col + DIM_W'(1);
    row_d   = col_end ? i_row + DIM_W'(1) : i_row;
    base_d  = col_end ? i_base + WADDR_W'(i_stride) : i_base;
  end

  // Control FSM with registered address, busy and done.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      rows_q    <= '0;
      cols_q    <= '0;
      stride_q  <= '0;
      row_q     <= '0;
      col_q     <= '0;
      base_q    <= '0;
      rd_addr_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (issue) begin
        rd_addr_q <= {i_word, 2'b00};
        col_q     <= col_d;
        row_q     <= row_d;
        base_q    <= base_d;
      end
      case (state_q)
        StIdle: begin
          if (start_ok) begin
            rows_q   <= cfg_rows_i;
            cols_q   <= cfg_cols_i;
            stride_q <= cfg_stride_i;
            busy_q   <= 1'b1;
            state_q  <= i_last ? StDrain : StFetch;
          end else if (start_zero) begin
            done_q <= 1'b1;
          end
        end
        StFetch: begin
          if (issue && i_last) state_q <= StDrain;
        end
        StDrain: begin
          if (pop && out_last_o) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Two-stage valid/last shadow of the BRAM read latency.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      s1_v_q <= 1'b0;
      s1_l_q <= 1'b0;
      s2_v_q <= 1'b0;
      s2_l_q <= 1'b0;
    end else begin
      s1_v_q <= issue;
      s1_l_q <= issue & i_last;
      s2_v_q <= s1_v_q;
      s2_l_q <= s1_l_q;
    end
  end

  // Skid FIFO; credits guarantee a push never meets a full FIFO without a pop.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        data_q[i] <= '0;
        last_q[i] <= 1'b0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        data_q[wr_ptr_q] <= bram_data_i;
        last_q[wr_ptr_q] <= s2_l_q;
        wr_ptr_q <= (wr_ptr_q == PtrW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PtrW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CntW'(1);
      end else if (!push && pop) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

endmodule

// File: tb/tb_ifm_fetch_ctrl.sv
// Self-checking bench for ifm_fetch_ctrl: a BRAM model plus a tile-level reference
// (expected beats from row/col arithmetic, credit from issued-minus-accepted counts).
module tb_ifm_fetch_ctrl;
  localparam int unsigned DATA_W = 32, RADDR_W = 20, WADDR_W = 18, DIM_W = 10;
  localparam int unsigned FIFO_DEPTH = 4;

  logic clk = 1'b0, reset = 1'b0, start = 1'b0, out_ready = 1'b1;
  logic [WADDR_W-1:0] cfg_base = '0;
  logic [DIM_W-1:0]   cfg_rows = '0, cfg_cols = '0, cfg_stride = '0;
  logic [RADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0]  bram_q, out_data;
  logic               out_valid, out_last, busy, done;

  always #5 clk = ~clk;

  ifm_fetch_ctrl #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .WADDR_W(WADDR_W), .DIM_W(DIM_W),
                   .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .cfg_base_i(cfg_base),
    .cfg_rows_i(cfg_rows), .cfg_cols_i(cfg_cols), .cfg_stride_i(cfg_stride),
    .rd_addr_o(rd_addr), .bram_data_i(bram_q), .out_data_o(out_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_last_o(out_last),
    .busy_o(busy), .done_o(done)
  );

  function automatic logic [31:0] bram_word(input logic [17:0] w);
    return ({14'd0, w} * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  // Registered-read BRAM, word index = byte address / 4.
  always @(posedge clk) bram_q <= bram_word(rd_addr[19:2]);

  int n_checks = 0, n_pass = 0;
  logic [31:0] got_data[$], exp_data[$];
  logic        got_last[$], exp_last[$];
  int          got_cyc[$];
  logic [19:0] exp_addr[$], addr_log[$];
  logic [19:0] model_last_addr = '0;
  int done_cnt, done_cyc, busy_cnt, valid_cnt, stable_err, credit_err, max_out;
  int first_valid_cyc, stray;
  logic busy_at_done;

  task automatic build_expected(input logic [17:0] b, input int r, input int c, input int s);
    exp_data.delete(); exp_last.delete(); exp_addr.delete();
    for (int i = 0; i < r; i++) begin
      for (int j = 0; j < c; j++) begin
        logic [17:0] w;
        w = b + 18'(i * s) + 18'(j);
        exp_data.push_back(bram_word(w));
        exp_last.push_back((i == r - 1) && (j == c - 1));
        exp_addr.push_back({w, 2'b00});
      end
    end
    if (r * c > 0) model_last_addr = exp_addr[exp_addr.size() - 1];
  endtask

  function automatic logic ready_pick(input int mode, input int k);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (k % 3) == 0;
    return $urandom_range(0, 1) != 0;
  endfunction

  // Runs one tile and logs what the DUT did; the calling test judges the log.
  task automatic run_tile(input logic [17:0] b, input int r, input int c, input int s,
                          input int mode, input int budget, input int restart_at);
    int k, total, issued, pred, accepted, outst;
    logic [19:0] prev_addr;
    logic [31:0] hold_d;
    logic hold_l;
    bit holding, fin, pop;
    got_data.delete(); got_last.delete(); got_cyc.delete(); addr_log.delete();
    done_cnt = 0; done_cyc = -1; busy_cnt = 0; valid_cnt = 0; stable_err = 0;
    credit_err = 0; max_out = 0; first_valid_cyc = -1; stray = 0; busy_at_done = 1'b0;
    total = r * c; issued = (total > 0) ? 1 : 0; pred = issued; accepted = 0;
    holding = 0; fin = 0; hold_d = '0; hold_l = 1'b0; prev_addr = '0;
    @(posedge clk); #1;
    cfg_base = b; cfg_rows = 10'(r); cfg_cols = 10'(c); cfg_stride = 10'(s);
    start = 1'b1; out_ready = ready_pick(mode, 0);
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (!fin && k < budget) begin
      if (k == restart_at) begin
        start = 1'b1; cfg_base = b + 18'd100; cfg_rows = 10'd3; cfg_cols = 10'd5;
        cfg_stride = 10'd7;
      end else begin
        start = 1'b0;
      end
      out_ready = ready_pick(mode, k);
      @(negedge clk);
      addr_log.push_back(rd_addr);
      if (k > 0) begin
        if (rd_addr != prev_addr) issued++;
        if (issued != pred) credit_err++;
      end
      prev_addr = rd_addr;
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; done_cyc = k; busy_at_done = busy; fin = 1; end
      outst = issued - accepted;
      if (outst > max_out) max_out = outst;
      pop = out_valid && out_ready;
      if (out_valid) begin
        valid_cnt++;
        if (first_valid_cyc < 0) first_valid_cyc = k;
        if (holding && (out_data !== hold_d || out_last !== hold_l)) stable_err++;
      end else if (holding) begin
        stable_err++;
      end
      holding = out_valid && !out_ready; hold_d = out_data; hold_l = out_last;
      if (pop) begin
        got_data.push_back(out_data); got_last.push_back(out_last); got_cyc.push_back(k);
        accepted++;
      end
      pred = issued + (((issued < total) && ((outst - int'(pop)) < int'(FIFO_DEPTH))) ? 1 : 0);
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0; out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (out_valid) stray++;
      if (done) done_cnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    n_checks++; if (rd_addr !== '0) $display("FAIL reset_rd_addr: got %h want 0", rd_addr); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (out_last !== 1'b0) $display("FAIL reset_last: got %b want 0", out_last); else n_pass++;
    n_checks++; if (out_data !== '0) $display("FAIL reset_data: got %h want 0", out_data); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
    @(posedge clk); @(posedge clk); #3 reset = 1'b0;
  endtask

  task automatic test_basic();
    build_expected(18'h10, 2, 3, 8);
    run_tile(18'h10, 2, 3, 8, 0, 60, -1);
    n_checks++; if (got_data.size() != 6) $display("FAIL basic_beats: got %0d want 6", got_data.size()); else n_pass++;
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (i >= addr_log.size() || addr_log[i] !== exp_addr[i])
        $display("FAIL basic_addr[%0d]: got %h want %h", i, (i < addr_log.size()) ? addr_log[i] : 20'hx, exp_addr[i]);
      else n_pass++;
      if (i < got_data.size()) begin
        n_checks++; if (got_data[i] !== exp_data[i]) $display("FAIL basic_data[%0d]: got %h want %h", i, got_data[i], exp_data[i]); else n_pass++;
        n_checks++; if (got_last[i] !== exp_last[i]) $display("FAIL basic_last[%0d]: got %b want %b", i, got_last[i], exp_last[i]); else n_pass++;
      end
    end
    n_checks++; if (first_valid_cyc != 2) $display("FAIL basic_latency: got %0d want 2", first_valid_cyc); else n_pass++;
    if (got_cyc.size() == 6) begin
      n_checks++; if (got_cyc[5] - got_cyc[0] != 5) $display("FAIL basic_throughput: got span %0d want 5", got_cyc[5] - got_cyc[0]); else n_pass++;
      n_checks++; if (done_cyc != got_cyc[5] + 1) $display("FAIL basic_done_time: got %0d want %0d", done_cyc, got_cyc[5] + 1); else n_pass++;
    end
    n_checks++; if (done_cnt != 1) $display("FAIL basic_done_cnt: got %0d want 1", done_cnt); else n_pass++;
    n_checks++; if (busy_at_done !== 1'b0) $display("FAIL basic_busy_at_done: got %b want 0", busy_at_done); else n_pass++;
    n_checks++; if (stray != 0) $display("FAIL basic_stray: got %0d want 0", stray); else n_pass++;
    n_checks++; if (credit_err != 0) $display("FAIL basic_credit: got %0d want 0", credit_err); else n_pass++;
  endtask

  task automatic test_back_pressure();
    build_expected(18'h200, 1, 8, 1);
    run_tile(18'h200, 1, 8, 1, 1, 200, -1);
    n_checks++; if (got_data.size() != 8) $display("FAIL bp_beats: got %0d want 8", got_data.size()); else n_pass++;
    for (int i = 0; i < got_data.size() && i < 8; i++) begin
      n_checks++; if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i])
        $display("FAIL bp_beat[%0d]: got %h/%b want %h/%b", i, got_data[i], got_last[i], exp_data[i], exp_last[i]);
      else n_pass++;
    end
    n_checks++; if (stable_err != 0) $display("FAIL bp_stable: got %0d want 0", stable_err); else n_pass++;
    n_checks++; if (credit_err != 0) $display("FAIL bp_credit: got %0d want 0", credit_err); else n_pass++;
    n_checks++; if (max_out != int'(FIFO_DEPTH)) $display("FAIL bp_max_outstanding: got %0d want %0d", max_out, FIFO_DEPTH); else n_pass++;
    n_checks++; if (done_cnt != 1) $display("FAIL bp_done_cnt: got %0d want 1", done_cnt); else n_pass++;
    n_checks++; if (stray != 0) $display("FAIL bp_stray: got %0d want 0", stray); else n_pass++;
  endtask

  task automatic test_zero_size();
    logic [19:0] prev;
    prev = model_last_addr;
    run_tile(18'h55, 3, 0, 4, 0, 10, -1);
    n_checks++; if (done_cnt != 1) $display("FAIL zero_done_cnt: got %0d want 1", done_cnt); else n_pass++;
    n_checks++; if (done_cyc != 0) $display("FAIL zero_done_time: got %0d want 0", done_cyc); else n_pass++;
    n_checks++; if (busy_cnt != 0) $display("FAIL zero_busy: got %0d want 0", busy_cnt); else n_pass++;
    n_checks++; if (addr_log.size() == 0 || addr_log[0] !== prev)
      $display("FAIL zero_rd_addr: got %h want %h", (addr_log.size() > 0) ? addr_log[0] : 20'hx, prev);
    else n_pass++;
    n_checks++; if (valid_cnt != 0 || stray != 0) $display("FAIL zero_valid: got %0d want 0", valid_cnt + stray); else n_pass++;
  endtask

  task automatic test_addr_wrap();
    build_expected(18'h3FFFE, 1, 4, 4);
    run_tile(18'h3FFFE, 1, 4, 4, 0, 40, -1);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (i >= addr_log.size() || addr_log[i] !== exp_addr[i])
        $display("FAIL wrap_addr[%0d]: got %h want %h", i, (i < addr_log.size()) ? addr_log[i] : 20'hx, exp_addr[i]);
      else n_pass++;
    end
    n_checks++; if (got_data.size() != 4) $display("FAIL wrap_beats: got %0d want 4", got_data.size()); else n_pass++;
    for (int i = 0; i < got_data.size() && i < 4; i++) begin
      n_checks++; if (got_data[i] !== exp_data[i]) $display("FAIL wrap_data[%0d]: got %h want %h", i, got_data[i], exp_data[i]); else n_pass++;
    end
    n_checks++; if (done_cnt != 1) $display("FAIL wrap_done_cnt: got %0d want 1", done_cnt); else n_pass++;
  endtask

  task automatic test_reset_mid_tile();
    int seen, k;
    seen = 0; k = 0;
    @(posedge clk); #1;
    cfg_base = 18'h1000; cfg_rows = 10'd4; cfg_cols = 10'd4; cfg_stride = 10'd16;
    start = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    while (seen < 3 && k < 40) begin
      @(negedge clk);
      if (out_valid && out_ready) seen++;
      k++;
    end
    n_checks++; if (seen != 3) $display("FAIL rmt_wait: got %0d beats want 3", seen); else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_checks++; if (rd_addr !== '0 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL rmt_ctrl_zero: got addr %h busy %b done %b want 0 0 0", rd_addr, busy, done);
    else n_pass++;
    n_checks++; if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== '0)
      $display("FAIL rmt_stream_zero: got v %b l %b d %h want 0 0 0", out_valid, out_last, out_data);
    else n_pass++;
    @(posedge clk); @(posedge clk); #3 reset = 1'b0;
    build_expected(18'h2345, 1, 2, 5);
    run_tile(18'h2345, 1, 2, 5, 0, 30, -1);
    n_checks++; if (got_data.size() != 2) $display("FAIL rmt_beats: got %0d want 2", got_data.size()); else n_pass++;
    for (int i = 0; i < got_data.size() && i < 2; i++) begin
      n_checks++; if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i])
        $display("FAIL rmt_beat[%0d]: got %h/%b want %h/%b", i, got_data[i], got_last[i], exp_data[i], exp_last[i]);
      else n_pass++;
    end
    n_checks++; if (done_cnt != 1 || stray != 0) $display("FAIL rmt_done: got done %0d stray %0d want 1 0", done_cnt, stray); else n_pass++;
  endtask

  task automatic test_start_while_busy();
    build_expected(18'h400, 3, 4, 6);
    run_tile(18'h400, 3, 4, 6, 2, 300, 2);
    n_checks++; if (got_data.size() != 12) $display("FAIL swb_beats: got %0d want 12", got_data.size()); else n_pass++;
    for (int i = 0; i < got_data.size() && i < 12; i++) begin
      n_checks++; if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i])
        $display("FAIL swb_beat[%0d]: got %h/%b want %h/%b", i, got_data[i], got_last[i], exp_data[i], exp_last[i]);
      else n_pass++;
    end
    n_checks++; if (done_cnt != 1) $display("FAIL swb_done_cnt: got %0d want 1", done_cnt); else n_pass++;
    n_checks++; if (stray != 0 || stable_err != 0 || credit_err != 0)
      $display("FAIL swb_stream: got stray %0d stable %0d credit %0d want 0 0 0", stray, stable_err, credit_err);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int t = 0; t < 6; t++) begin
      logic [17:0] b;
      int r, c, s;
      b = 18'($urandom);
      r = int'($urandom_range(1, 4));
      c = int'($urandom_range(1, 6));
      s = c + int'($urandom_range(0, 20));
      build_expected(b, r, c, s);
      run_tile(b, r, c, s, 2, 400, -1);
      n_checks++; if (got_data.size() != r * c) $display("FAIL rnd%0d_beats: got %0d want %0d", t, got_data.size(), r * c); else n_pass++;
      for (int i = 0; i < got_data.size() && i < r * c; i++) begin
        n_checks++; if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i])
          $display("FAIL rnd%0d_beat[%0d]: got %h/%b want %h/%b", t, i, got_data[i], got_last[i], exp_data[i], exp_last[i]);
        else n_pass++;
      end
      n_checks++; if (done_cnt != 1 || stray != 0) $display("FAIL rnd%0d_done: got done %0d stray %0d want 1 0", t, done_cnt, stray); else n_pass++;
      n_checks++; if (stable_err != 0 || credit_err != 0)
        $display("FAIL rnd%0d_flow: got stable %0d credit %0d want 0 0", t, stable_err, credit_err);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_pressure();
    test_addr_wrap();
    test_zero_size();
    test_reset_mid_tile();
    test_start_while_busy();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
